// File: rtl/arb_pkg.sv
// Shared types for the weighted round-robin arbiter: ownership state and
// the index-width helper used by the top level and the rotating picker.
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating first-one search: returns the first set req bit at or above ptr,
// wrapping from N-1 back to 0. Purely combinational.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]          req,
    input  logic [idx_w(N)-1:0]   ptr,
    output logic [idx_w(N)-1:0]   index,
    output logic                  valid
);

    localparam int IW = idx_w(N);

    int c;

    // Walk the offsets downward so the smallest offset from ptr wins last.
    always_comb begin
        index = '0;
        valid = |req;
        c     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            c = int'(ptr) + k;
            if (c >= N) c = c - N;
            if (req[c]) index = IW'(c);
        end
    end

endmodule

// File: rtl/arb_wrr.sv
// Weighted round-robin channel arbiter with per-transaction ownership.
// Define ARB_WRR_WEIGHT_EN to let weight_i set the transactions per ownership.
module arb_wrr
    import arb_pkg::*;
#(
    parameter int N  = 8,
    parameter int WW = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [N-1:0]          req_i,
    input  logic [N-1:0]          last_i,
    input  logic [N*WW-1:0]       weight_i,
    output logic [N-1:0]          ack_i,
    output logic                  req_o,
    input  logic                  ack_o,
    output logic [idx_w(N)-1:0]   gnt_id_o,
    output logic                  busy_o
);

    localparam int IW = idx_w(N);

    state_t          state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   ptr;
    logic [WW-1:0]   cnt;
    logic            inflight;

    logic [IW-1:0]   pick_idx;
    logic            pick_vld;
    logic [WW-1:0]   load_val;
    logic            own_req;
    logic            own_last;
    logic            beat;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (int'(i) == N - 1) ? '0 : i + 1'b1;
    endfunction

    rr_pick #(.N(N)) u_pick (
        .req   (req_i),
        .ptr   (ptr),
        .index (pick_idx),
        .valid (pick_vld)
    );

`ifdef ARB_WRR_WEIGHT_EN
    logic [WW-1:0] pick_w;
    assign pick_w   = weight_i[pick_idx*WW +: WW];
    assign load_val = (pick_w == '0) ? WW'(1) : pick_w;
`else
    logic unused_weight;
    assign unused_weight = ^weight_i;
    assign load_val      = WW'(1);
`endif

    assign own_req  = req_i[owner];
    assign own_last = last_i[owner];
    assign beat     = (state == OWN) & own_req & ack_o;
    assign req_o    = (state == OWN) & own_req;
    assign busy_o   = (state == OWN);
    assign gnt_id_o = owner;

    always_comb begin
        ack_i        = '0;
        ack_i[owner] = beat;
    end

    // An inflight transaction pins the owner; release happens only between transactions.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            cnt      <= '0;
            inflight <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    inflight <= 1'b0;
                    if (pick_vld) begin
                        owner <= pick_idx;
                        cnt   <= load_val;
                        state <= OWN;
                    end
                end
                OWN: begin
                    if (beat) begin
                        if (!own_last) begin
                            inflight <= 1'b1;
                        end else begin
                            inflight <= 1'b0;
                            cnt      <= cnt - 1'b1;
                            if (cnt <= WW'(1)) begin
                                ptr   <= next_idx(owner);
                                state <= IDLE;
                            end
                        end
                    end else if (!own_req && !inflight) begin
                        ptr   <= next_idx(owner);
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/arb_wrr.md
ARB_WRR -- requirements
Module: arb_wrr

Interface
REQ-001 SHALL have parameter N, default 8: number of requesters, 2..32.
REQ-002 SHALL have parameter WW, default 4: weight field width, in bits.
REQ-003 SHALL have port clk  input  1  clock, rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_i  input  N  per-requester request, held until its beat is acknowledged.
REQ-006 SHALL have port last_i  input  N  per-requester last-beat marker, sampled on an acknowledged beat.
REQ-007 SHALL have port weight_i  input  N*WW  per-requester weight, slice [i*WW +: WW].
REQ-008 SHALL have port ack_i  output  N  per-requester beat acknowledge, one-hot or zero.
REQ-009 SHALL have port req_o  output  1  downstream request.
REQ-010 SHALL have port ack_o  input  1  downstream acknowledge.
REQ-011 SHALL have port gnt_id_o  output  $clog2(N)  current owner index.
REQ-012 SHALL have port busy_o  output  1  high while a requester owns the channel.

Function
REQ-013 SHALL implement two states: IDLE and OWN.
REQ-014 SHALL define a beat as req_i[owner] & ack_o while in OWN; ack_i[owner] SHALL equal that beat, combinationally.
REQ-015 In IDLE, if |req_i, the block SHALL latch owner = the first set req_i bit searching upward from ptr (wrapping N-1 to 0), load cnt, and enter OWN next cycle; IDLE-to-OWN costs exactly one bubble cycle.
REQ-016 In IDLE, req_o, ack_i and busy_o SHALL be 0; in OWN, req_o = req_i[owner] and busy_o = 1.
REQ-017 cnt load value SHALL be weight_i[owner]; weight 0 SHALL be treated as 1.
REQ-018 A beat with last_i[owner]=0 SHALL set the inflight flag; a beat with last_i[owner]=1 SHALL clear it and decrement cnt.
REQ-019 On a last beat with cnt==1, the block SHALL set ptr = (owner+1) mod N and return to IDLE.
REQ-020 On a last beat with cnt>1, the block SHALL stay in OWN; the owner keeps the channel for its next transaction with no bubble.
REQ-021 In OWN with req_i[owner]=0 and inflight=0, the block SHALL release: ptr = (owner+1) mod N, state goes to IDLE.
REQ-022 While inflight=1, the owner SHALL never be pre-empted, whatever other requests are pending.
REQ-023 weight_i SHALL be sampled only at owner selection; later changes SHALL affect only the next ownership.
REQ-024 Non-owner ack_i bits SHALL be 0 at all times.

Reset
REQ-025 rstn low SHALL immediately force: state IDLE, ptr 0, owner 0, cnt 0, inflight 0, and all outputs 0.
REQ-026 Reset mid-transaction SHALL abandon the transaction; no partial state SHALL survive.

Configuration
REQ-027 With macro ARB_WRR_WEIGHT_EN defined, cnt SHALL load from weight_i per REQ-017.
REQ-028 Without ARB_WRR_WEIGHT_EN, cnt SHALL always load 1, giving plain per-transaction round robin.
REQ-029 Without ARB_WRR_WEIGHT_EN, weight_i SHALL remain a port and SHALL be ignored.

Structure
REQ-030 Shared package arb_pkg SHALL hold the state enum (IDLE, OWN) and the function computing the index width from N.
REQ-031 The rotating first-one search SHALL be sub-module rr_pick: inputs req and ptr, outputs index and valid; purely combinational.

Verification
REQ-032 Reset: rstn low for 3 cycles with req_i=8'hFF -> ack_i=0, req_o=0, gnt_id_o=0, busy_o=0.
REQ-033 Plain rotation: req_i=8'hFF, single-beat transactions, ack_o=1 -> gnt_id_o steps 0,1,...,7,0 with one IDLE bubble between owners.
REQ-034 Weighted (macro on): weights 3,1,1... and req_i=8'h03 -> requester 0 gets 3 consecutive transactions, then requester 1 gets 1, repeating.
REQ-035 No pre-emption: 4-beat burst from requester 2 with ack_o toggling, req_i[5] raised mid-burst -> ack_i[5] stays 0 until after requester 2's last beat.
REQ-036 Early drop: owner 4 with weight 5 drops req_i after 1 transaction -> release, ptr=5, requester 6 granted next when req_i=8'h41.
REQ-037 Reset mid-burst: rstn low during the 2nd beat -> next grant after reset goes to the lowest requesting index, starting from ptr=0.
